// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit access into two
// fixed-wait-state 16-bit SRAM transactions and stalls the pipeline meanwhile.
module mem_stage_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        freeze,
  output logic        busy,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_we_n
);

  localparam int unsigned   CW   = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [31:0]   BASE = 32'(ADDR_BASE);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          wr_q, wr_d;
  logic          req;
  logic [10:0]   widx_in;

  assign req     = MEM_R_EN | MEM_W_EN;
  // Only the low 11 bits of the rebased address select a word.
  assign widx_in = (ALU_Res >= BASE) ? 11'(ALU_Res - BASE) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          widx_d  = widx_in;
          wdata_d = Val_Rm;
          wr_d    = MEM_W_EN;
          cnt_d   = '0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (cnt_q == LAST) begin
          if (!wr_q) rdata_d[15:0] = sram_rdata;
          cnt_d   = '0;
          state_d = S_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HI: begin
        if (cnt_q == LAST) begin
          if (!wr_q) rdata_d[31:16] = sram_rdata;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    case (state_q)
      S_LO: begin
        sram_addr  = {6'b0, widx_q, 1'b0};
        sram_wdata = wdata_q[15:0];
        sram_we_n  = ~wr_q;
      end
      S_HI: begin
        sram_addr  = {6'b0, widx_q, 1'b1};
        sram_wdata = wdata_q[31:16];
        sram_we_n  = ~wr_q;
      end
      default: ;
    endcase
  end

  assign ready     = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign freeze    = req & ~ready;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: a W=5 instance and a W=1 instance,
// each backed by a small behavioural SRAM.
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        r0, w0, rdy0, frz0, bsy0, we0;
  logic [31:0] a0, d0, rd0;
  logic [17:0] sa0;
  logic [15:0] sw0, sr0;

  logic        r1, w1, rdy1, frz1, bsy1, we1;
  logic [31:0] a1, d1, rd1;
  logic [17:0] sa1;
  logic [15:0] sw1, sr1;

  logic [15:0] mem0 [0:63];
  logic [15:0] mem1 [0:63];

  assign sr0 = mem0[sa0[5:0]];
  assign sr1 = mem1[sa1[5:0]];
  always @(posedge clk) if (!we0) mem0[sa0[5:0]] <= sw0;
  always @(posedge clk) if (!we1) mem1[sa1[5:0]] <= sw1;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(5), .ADDR_BASE(1024)) u_dut5 (
    .clk(clk), .rst(rst), .MEM_R_EN(r0), .MEM_W_EN(w0), .ALU_Res(a0), .Val_Rm(d0),
    .read_data(rd0), .ready(rdy0), .freeze(frz0), .busy(bsy0),
    .sram_addr(sa0), .sram_wdata(sw0), .sram_rdata(sr0), .sram_we_n(we0)
  );

  mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .ADDR_BASE(1024)) u_dut1 (
    .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(w1), .ALU_Res(a1), .Val_Rm(d1),
    .read_data(rd1), .ready(rdy1), .freeze(frz1), .busy(bsy1),
    .sram_addr(sa1), .sram_wdata(sw1), .sram_rdata(sr1), .sram_we_n(we1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One access on the W=5 instance; cycle 0 is the IDLE cycle seeing the request.
  task automatic acc5(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [17:0] sa, input int drop_at, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    r0 = r; w0 = w; a0 = a; d0 = d;
    @(negedge clk);
    chk("c0_busy", 32'(bsy0), 32'd0);
    chk("c0_freeze", 32'(frz0), 32'd1);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin a0 = ~a; d0 = ~d; end
      if (c == drop_at) begin r0 = 1'b0; w0 = 1'b0; end
      @(negedge clk);
      if (c <= 10) begin
        chk($sformatf("c%0d_busy", c), 32'(bsy0), 32'd1);
        chk($sformatf("c%0d_ready", c), 32'(rdy0), 32'd0);
        chk($sformatf("c%0d_freeze", c), 32'(frz0),
            (drop_at != 0 && c >= drop_at) ? 32'd0 : 32'd1);
        chk($sformatf("c%0d_we_n", c), 32'(we0), w ? 32'd0 : 32'd1);
        chk($sformatf("c%0d_addr", c), 32'(sa0), (c <= 5) ? 32'(sa) : 32'(sa) + 32'd1);
        if (w) chk($sformatf("c%0d_wdata", c), 32'(sw0),
                   (c <= 5) ? 32'(d[15:0]) : 32'(d[31:16]));
      end else begin
        chk("c11_ready", 32'(rdy0), 32'd1);
        chk("c11_freeze", 32'(frz0), 32'd0);
        chk("c11_we_n", 32'(we0), 32'd1);
        chk("c11_addr", 32'(sa0), 32'd0);
        chk("c11_rdata", rd0, exp_rd);
      end
    end
  endtask

  task automatic acc1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [17:0] sa, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    r1 = r; w1 = w; a1 = a; d1 = d;
    @(negedge clk);
    chk("w1_c0_busy", 32'(bsy1), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin a1 = ~a; d1 = ~d; end
      @(negedge clk);
      if (c < 3) begin
        chk($sformatf("w1_c%0d_ready", c), 32'(rdy1), 32'd0);
        chk($sformatf("w1_c%0d_we_n", c), 32'(we1), w ? 32'd0 : 32'd1);
        chk($sformatf("w1_c%0d_addr", c), 32'(sa1), 32'(sa) + 32'(c - 1));
      end else begin
        chk("w1_c3_ready", 32'(rdy1), 32'd1);
        chk("w1_c3_rdata", rd1, exp_rd);
      end
    end
  endtask

  task automatic idle5();
    @(posedge clk); #1;
    r0 = 1'b0; w0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    r0 = 0; w0 = 0; a0 = '0; d0 = '0;
    r1 = 0; w1 = 0; a1 = '0; d1 = '0;
    rst = 1'b1;
    #12;
    chk("rst_rdata", rd0, 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_busy", 32'(bsy0), 32'd0);
    chk("rst_addr", 32'(sa0), 32'd0);
    chk("rst_wdata", 32'(sw0), 32'd0);
    chk("rst_we_n", 32'(we0), 32'd1);
    chk("rst_freeze0", 32'(frz0), 32'd0);
    r0 = 1'b1; #1;
    chk("rst_freeze1", 32'(frz0), 32'd1);
    r0 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    acc5(1'b0, 1'b1, 32'd1029, 32'hDEADBEEF, 18'd10, 0, 32'd0);
    chk("mem10", 32'(mem0[10]), 32'h0000BEEF);
    chk("mem11", 32'(mem0[11]), 32'h0000DEAD);
    idle5();
    acc5(1'b1, 1'b0, 32'd1029, 32'd0, 18'd10, 0, 32'hDEADBEEF);
    idle5();
    acc5(1'b1, 1'b1, 32'd500, 32'h12345678, 18'd0, 0, 32'hDEADBEEF);
    chk("mem0", 32'(mem0[0]), 32'h00005678);
    chk("mem1", 32'(mem0[1]), 32'h00001234);
    idle5();
    acc5(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 3, 32'h12345678);
    idle5();

    // Reset lands in the HI phase of a write.
    @(posedge clk); #1;
    w0 = 1'b1; a0 = 32'd1031; d0 = 32'hCAFEF00D;
    repeat (7) @(posedge clk);
    #1;
    chk("hi_we_n", 32'(we0), 32'd0);
    chk("hi_addr", 32'(sa0), 32'd15);
    rst = 1'b1; #1;
    chk("mid_rst_we_n", 32'(we0), 32'd1);
    chk("mid_rst_busy", 32'(bsy0), 32'd0);
    chk("mid_rst_rdata", rd0, 32'd0);
    chk("mid_rst_addr", 32'(sa0), 32'd0);
    chk("mem14", 32'(mem0[14]), 32'h0000F00D);
    @(posedge clk); #1;
    rst = 1'b0; w0 = 1'b0;

    acc5(1'b1, 1'b0, 32'd1024 + 32'd2048 + 32'd5, 32'd0, 18'd10, 0, 32'hDEADBEEF);
    acc5(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 0, 32'h12345678);
    idle5();

    acc1(1'b0, 1'b1, 32'd1025, 32'hA5A55A5A, 18'd2, 32'd0);
    acc1(1'b1, 1'b0, 32'd1025, 32'd0, 18'd2, 32'hA5A55A5A);
    @(posedge clk); #1;
    r1 = 1'b0; w1 = 1'b0;
    @(negedge clk);
    chk("w1_idle_busy", 32'(bsy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Multi-cycle controller that sequences 32-bit data-memory accesses from the MEM stage onto an external 16-bit, fixed-wait-state SRAM. Each access is split into two half-word transactions (low then high). While an access is in progress the controller stalls the pipeline through `freeze` and releases it with a one-cycle `ready`. It sits between the MEM stage pipeline register and the off-chip memory, and replaces direct array access for the data memory.

## Interface
Parameters:
- `WAIT_CYCLES`, default 5: cycles each half-word transaction holds address/data on the SRAM bus; legal range ≥1.
- `ADDR_BASE`, default 1024: data-segment base subtracted from the incoming address.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `MEM_R_EN`  in  1  load request from MEM stage
- `MEM_W_EN`  in  1  store request from MEM stage
- `ALU_Res`  in  32  byte-agnostic word address from EXE
- `Val_Rm`  in  32  store data
- `read_data`  out  32  assembled load result, valid when `ready`=1 after a read
- `ready`  out  1  access complete, one-cycle pulse
- `freeze`  out  1  pipeline stall request
- `busy`  out  1  FSM not in IDLE
- `sram_addr`  out  18  SRAM half-word address
- `sram_wdata`  out  16  SRAM write data
- `sram_rdata`  in  16  SRAM read data, sampled on last wait cycle
- `sram_we_n`  out  1  SRAM write strobe, active low

## Operation
- Address: `adj = (ALU_Res >= ADDR_BASE) ? ALU_Res - ADDR_BASE : 0`; word index `w = adj[10:0]` (upper bits discarded); `sram_addr = {6'b0, w, half}`, `half` = 0 for low, 1 for high.
- Request = `MEM_R_EN | MEM_W_EN`; both asserted → treated as write, `read_data` unchanged.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: on request, latch address, `Val_Rm` and op type → LO, counter cleared. Otherwise stay.
  - LO: drive low half-word (`Val_Rm[15:0]` on write). Counter increments each cycle; on count = WAIT_CYCLES-1, capture `sram_rdata` into `read_data[15:0]` (read only) → HI, counter cleared.
  - HI: same for high half (`Val_Rm[31:16]` / `read_data[31:16]`); on final count → DONE.
  - DONE: `ready`=1 for exactly this cycle → IDLE unconditionally.
- `sram_we_n` = 0 throughout LO and HI of a write; 1 in all other states and for reads. `sram_addr`/`sram_wdata` are driven from latched values, stable for the whole phase; 0 in IDLE/DONE.
- `freeze = request & ~ready` (combinational); `busy = (state != IDLE)`.
- Request deasserted mid-access (flush): access still completes and `ready` still pulses; writes are never aborted.
- Inputs changing during LO/HI are ignored (latched copies used).
- Counter width `$clog2(WAIT_CYCLES)+1`, no wrap within a phase.

## Timing
- Reset (async, immediate): state=IDLE, counter=0, `read_data`=0, `ready`=0, `busy`=0, `sram_addr`=0, `sram_wdata`=0, `sram_we_n`=1; `freeze` follows the request combinationally. Reset mid-access abandons it; a partially written word is not repaired.
- Request seen in IDLE at cycle 0 → LO cycles 1..W, HI cycles W+1..2W, DONE at cycle 2W+1 (W=5: `ready` at cycle 11; `freeze` high cycles 0..10).
- `read_data` is final from the HI capture edge onward and holds until the next read capture.
- Back-to-back: the new request is visible in IDLE the cycle after DONE; no extra bubble beyond that IDLE cycle.
- WAIT_CYCLES=1: each phase lasts one cycle, `ready` at cycle 3.

## Test plan
- Write `ALU_Res`=1024+5, `Val_Rm`=0xDEADBEEF, W=5 → `sram_we_n`=0 for cycles 1..10; `sram_addr`=10 carrying 0xBEEF in cycles 1..5, `sram_addr`=11 carrying 0xDEAD in cycles 6..10; `ready` pulse at cycle 11; `freeze`=1 for cycles 0..10.
- Read the same address with an SRAM model → `read_data`=0xDEADBEEF when `ready`=1; `sram_we_n` stays 1.
- Address 500 (below base) → `sram_addr` 0 then 1; both R and W asserted → write performed and `read_data` unchanged.
- Drop `MEM_R_EN` at cycle 3 of a read → FSM still reaches DONE at cycle 11; `freeze`=0 from cycle 3.
- Assert `rst` during HI of a write → next cycle `sram_we_n`=1, `busy`=0, `read_data`=0; a subsequent read completes normally.
- Two back-to-back reads → second `ready` at cycle 11 after its IDLE cycle, with correct data; run with W=1 and `ready` at cycle 3.
